// File: rtl/tmds_pkg.sv
// Shared TMDS word-alignment definitions: word width, control symbols,
// control-symbol detector and the per-lane alignment state encoding.
package tmds_pkg;

  localparam int TMDS_WORD_W = 10;

  localparam logic [TMDS_WORD_W-1:0] CTRL_00 = 10'h354;
  localparam logic [TMDS_WORD_W-1:0] CTRL_01 = 10'h0AB;
  localparam logic [TMDS_WORD_W-1:0] CTRL_10 = 10'h154;
  localparam logic [TMDS_WORD_W-1:0] CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } lane_state_t;

  function automatic logic is_ctrl(input logic [TMDS_WORD_W-1:0] w);
    case (w)
      CTRL_00, CTRL_01, CTRL_10, CTRL_11: is_ctrl = 1'b1;
      default:                            is_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tmds_lane_aligner.sv
// One TMDS lane: IN_WIDTH-to-10 gearbox with bit slip, control-run based
// word alignment FSM, lock tracking and slip offset counter.
module tmds_lane_aligner
  import tmds_pkg::*;
#(
  parameter int IN_WIDTH     = 4,
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WORDS = 32,
  parameter int LOSS_WORDS   = 4096,
  parameter int SETTLE_WORDS = 2
) (
  input  logic                   clk_shift_half,
  input  logic                   rst_n,
  input  logic                   align_en,
  input  logic                   slip_req,
  input  logic [IN_WIDTH-1:0]    d,
  output logic [TMDS_WORD_W-1:0] word_o,
  output logic                   word_valid,
  output logic                   locked,
  output logic [3:0]             bit_offset
);

  localparam int BUF_W  = TMDS_WORD_W + IN_WIDTH - 1;
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int SRCH_W = $clog2(SEARCH_WORDS + 1);
  localparam int SETL_W = $clog2(SETTLE_WORDS + 1);
  localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

  logic [BUF_W-1:0]       buf_r, cat_s, rem_s;
  logic [FILL_W-1:0]      fill_r, fill_s, fill_nx;
  logic                   slip_s, emit_s, auto_slip_r, auto_nx;
  logic [TMDS_WORD_W-1:0] word_s;
  lane_state_t            state_r, state_nx;
  logic [RUN_W-1:0]       run_r, run_nx;
  logic [SRCH_W-1:0]      win_r, win_nx;
  logic [SETL_W-1:0]      settle_r, settle_nx;
  logic [LOSS_W-1:0]      loss_r, loss_nx;
  logic                   locked_nx;

  // Gearbox: append new bits above the fill, drop the oldest bit on a slip, then peel off a word
  always_comb begin
    slip_s = slip_req | (auto_slip_r & align_en);
    cat_s  = buf_r | (BUF_W'(d) << fill_r);
    fill_s = fill_r + FILL_W'(IN_WIDTH);
    if (slip_s) begin
      cat_s  = cat_s >> 1;
      fill_s = fill_s - FILL_W'(1);
    end else begin
      cat_s  = cat_s;
    end
    emit_s = (fill_s >= FILL_W'(TMDS_WORD_W));
    word_s = cat_s[TMDS_WORD_W-1:0];
    if (emit_s) begin
      rem_s   = cat_s >> TMDS_WORD_W;
      fill_nx = fill_s - FILL_W'(TMDS_WORD_W);
    end else begin
      rem_s   = cat_s;
      fill_nx = fill_s;
    end
  end

  // Gearbox state, registered word output and slip offset
  always_ff @(posedge clk_shift_half) begin
    if (!rst_n) begin
      buf_r      <= BUF_W'(0);
      fill_r     <= FILL_W'(0);
      word_o     <= TMDS_WORD_W'(0);
      word_valid <= 1'b0;
      bit_offset <= 4'd0;
    end else begin
      buf_r      <= rem_s;
      fill_r     <= fill_nx;
      word_valid <= emit_s;
      word_o     <= emit_s ? word_s : word_o;
      if (slip_s) begin
        bit_offset <= (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
      end else begin
        bit_offset <= bit_offset;
      end
    end
  end

  // Alignment FSM: judges the word being emitted this cycle so locked lines up with word_valid
  always_comb begin
    state_nx  = state_r;
    run_nx    = run_r;
    win_nx    = win_r;
    settle_nx = settle_r;
    loss_nx   = loss_r;
    locked_nx = locked_r_q();
    auto_nx   = 1'b0;
    if (slip_req) begin
      state_nx  = SETTLE;
      run_nx    = RUN_W'(0);
      win_nx    = SRCH_W'(0);
      settle_nx = SETL_W'(0);
      loss_nx   = LOSS_W'(0);
      locked_nx = 1'b0;
    end else if (emit_s) begin
      case (state_r)
        SEARCH: begin
          if (is_ctrl(word_s) && (run_r == RUN_W'(CTRL_RUN - 1))) begin
            state_nx  = LOCKED;
            locked_nx = 1'b1;
            run_nx    = RUN_W'(0);
            win_nx    = SRCH_W'(0);
            loss_nx   = LOSS_W'(0);
          end else if (win_r == SRCH_W'(SEARCH_WORDS - 1)) begin
            win_nx = SRCH_W'(0);
            run_nx = is_ctrl(word_s) ? run_r + RUN_W'(1) : RUN_W'(0);
            if (align_en) begin
              state_nx  = SETTLE;
              auto_nx   = 1'b1;
              run_nx    = RUN_W'(0);
              settle_nx = SETL_W'(0);
            end else begin
              state_nx = SEARCH;
            end
          end else begin
            win_nx = win_r + SRCH_W'(1);
            run_nx = is_ctrl(word_s) ? run_r + RUN_W'(1) : RUN_W'(0);
          end
        end
        SETTLE: begin
          if (settle_r == SETL_W'(SETTLE_WORDS - 1)) begin
            state_nx  = SEARCH;
            settle_nx = SETL_W'(0);
            run_nx    = RUN_W'(0);
            win_nx    = SRCH_W'(0);
          end else begin
            settle_nx = settle_r + SETL_W'(1);
          end
        end
        LOCKED: begin
          if (is_ctrl(word_s)) begin
            loss_nx = LOSS_W'(0);
          end else if (loss_r == LOSS_W'(LOSS_WORDS - 1)) begin
            state_nx  = SEARCH;
            locked_nx = 1'b0;
            loss_nx   = LOSS_W'(0);
            run_nx    = RUN_W'(0);
            win_nx    = SRCH_W'(0);
          end else begin
            loss_nx = loss_r + LOSS_W'(1);
          end
        end
        default: begin
          state_nx  = SEARCH;
          locked_nx = 1'b0;
        end
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  function automatic logic locked_r_q();
    return locked;
  endfunction

  // FSM state, counters, lock flag and the one-cycle auto slip pulse
  always_ff @(posedge clk_shift_half) begin
    if (!rst_n) begin
      state_r     <= SEARCH;
      run_r       <= RUN_W'(0);
      win_r       <= SRCH_W'(0);
      settle_r    <= SETL_W'(0);
      loss_r      <= LOSS_W'(0);
      locked      <= 1'b0;
      auto_slip_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      run_r       <= run_nx;
      win_r       <= win_nx;
      settle_r    <= settle_nx;
      loss_r      <= loss_nx;
      locked      <= locked_nx;
      auto_slip_r <= auto_nx;
    end
  end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS deserialiser back end: one independent word aligner per lane plus a
// registered all-lanes-locked flag.
module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int CHANNELS     = 3,
  parameter int IN_WIDTH     = 4,
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WORDS = 32,
  parameter int LOSS_WORDS   = 4096,
  parameter int SETTLE_WORDS = 2
) (
  input  logic                            clk_shift_half,
  input  logic                            rst_n,
  input  logic                            align_en,
  input  logic [CHANNELS-1:0]             slip_req,
  input  logic [CHANNELS*IN_WIDTH-1:0]    d,
  output logic [CHANNELS*TMDS_WORD_W-1:0] word_o,
  output logic [CHANNELS-1:0]             word_valid,
  output logic [CHANNELS-1:0]             locked,
  output logic                            all_locked,
  output logic [CHANNELS*4-1:0]           bit_offset
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    tmds_lane_aligner #(
      .IN_WIDTH    (IN_WIDTH),
      .CTRL_RUN    (CTRL_RUN),
      .SEARCH_WORDS(SEARCH_WORDS),
      .LOSS_WORDS  (LOSS_WORDS),
      .SETTLE_WORDS(SETTLE_WORDS)
    ) u_lane (
      .clk_shift_half(clk_shift_half),
      .rst_n         (rst_n),
      .align_en      (align_en),
      .slip_req      (slip_req[c]),
      .d             (d[c*IN_WIDTH +: IN_WIDTH]),
      .word_o        (word_o[c*TMDS_WORD_W +: TMDS_WORD_W]),
      .word_valid    (word_valid[c]),
      .locked        (locked[c]),
      .bit_offset    (bit_offset[c*4 +: 4])
    );
  end

  // Registered AND of the per-lane lock flags
  always_ff @(posedge clk_shift_half) begin
    if (!rst_n) begin
      all_locked <= 1'b0;
    end else begin
      all_locked <= &locked;
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Directed bench for tmds_word_aligner: gearbox vector table plus hand-written
// lock, misalignment, manual-slip and loss-of-lock sequences.
module tb_tmds_word_aligner;

  logic        clk_shift_half = 1'b0;
  logic        rst_n = 1'b0;
  logic        align_en = 1'b1;
  logic [2:0]  slip_req = 3'b000;
  logic [11:0] d = 12'h000;
  logic [29:0] word_o;
  logic [2:0]  word_valid;
  logic [2:0]  locked;
  logic        all_locked;
  logic [11:0] bit_offset;

  tmds_word_aligner dut (
    .clk_shift_half(clk_shift_half),
    .rst_n         (rst_n),
    .align_en      (align_en),
    .slip_req      (slip_req),
    .d             (d),
    .word_o        (word_o),
    .word_valid    (word_valid),
    .locked        (locked),
    .all_locked    (all_locked),
    .bit_offset    (bit_offset)
  );

  always #5 clk_shift_half = ~clk_shift_half;

  typedef struct {
    logic [3:0] nib;
    logic       slip;
    logic       vld;
    logic [9:0] word;
  } vec_t;

  vec_t       tbl [13];
  bit         lq [3][$];
  logic [9:0] fill_sym [3];
  int         tests = 0;
  int         fails = 0;
  int         wc, sc, zc;
  logic [3:0] prev_off;
  logic       moved;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_shift_half);
    #1;
  endtask

  task automatic push_word(input int c, input logic [9:0] w);
    for (int i = 0; i < 10; i++) lq[c].push_back(w[i]);
  endtask

  task automatic push_junk(input int c, input int n);
    for (int i = 0; i < n; i++) lq[c].push_back(1'b0);
  endtask

  task automatic tick();
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (lq[c].size() == 0) push_word(c, fill_sym[c]);
        d[c*4+b] = lq[c].pop_front();
      end
    end
    step();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    slip_req = 3'b000;
    for (int i = 0; i < 10; i++) begin
      d = 12'($urandom);
      step();
      chk("reset_hold", {15'd0, word_o, word_valid, locked, all_locked, bit_offset}, 64'd0);
    end
    for (int c = 0; c < 3; c++) lq[c].delete();
    rst_n = 1'b1;
  endtask

  initial begin
    // lane 0 nibble stream; row 9 slips in the cycle whose fill would reach exactly 10
    tbl[0]  = '{4'h1, 1'b0, 1'b0, 10'h000};
    tbl[1]  = '{4'h2, 1'b0, 1'b0, 10'h000};
    tbl[2]  = '{4'h3, 1'b0, 1'b1, 10'h321};
    tbl[3]  = '{4'h4, 1'b0, 1'b0, 10'h000};
    tbl[4]  = '{4'h5, 1'b0, 1'b1, 10'h150};
    tbl[5]  = '{4'h6, 1'b0, 1'b0, 10'h000};
    tbl[6]  = '{4'h7, 1'b0, 1'b0, 10'h000};
    tbl[7]  = '{4'h8, 1'b0, 1'b1, 10'h076};
    tbl[8]  = '{4'h9, 1'b0, 1'b0, 10'h000};
    tbl[9]  = '{4'hA, 1'b1, 1'b0, 10'h000};
    tbl[10] = '{4'hB, 1'b0, 1'b1, 10'h353};
    tbl[11] = '{4'hC, 1'b0, 1'b0, 10'h000};
    tbl[12] = '{4'hD, 1'b0, 1'b1, 10'h2E5};

    // gearbox table straight after reset
    align_en = 1'b1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      d        = {8'h00, tbl[i].nib};
      slip_req = {2'b00, tbl[i].slip};
      step();
      chk($sformatf("gb_valid_%0d", i), {63'd0, word_valid[0]}, {63'd0, tbl[i].vld});
      if (tbl[i].vld) chk($sformatf("gb_word_%0d", i), {54'd0, word_o[9:0]}, {54'd0, tbl[i].word});
    end
    slip_req = 3'b000;
    chk("gb_offset", {60'd0, bit_offset[3:0]}, 64'd1);

    // aligned lock on lane 0
    do_reset();
    fill_sym[0] = 10'h354; fill_sym[1] = 10'h000; fill_sym[2] = 10'h000;
    wc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (word_valid[0]) begin
        wc++;
        if (wc == 7) chk("al_not_yet", {63'd0, locked[0]}, 64'd0);
        if (wc == 8) begin
          chk("al_locked", {63'd0, locked[0]}, 64'd1);
          chk("al_offset", {60'd0, bit_offset[3:0]}, 64'd0);
          break;
        end
      end
    end
    chk("al_words", 64'(wc), 64'd8);

    // misaligned by 3 bits, automatic alignment
    do_reset();
    fill_sym[0] = 10'h0AB;
    push_junk(0, 3);
    wc = 0; sc = 0; prev_off = 4'd0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (word_valid[0]) wc++;
      if (bit_offset[3:0] != prev_off) sc++;
      prev_off = bit_offset[3:0];
      if (locked[0]) break;
    end
    chk("mis_locked", {63'd0, locked[0]}, 64'd1);
    chk("mis_slips", 64'(sc), 64'd3);
    chk("mis_offset", {60'd0, bit_offset[3:0]}, 64'd3);
    chk("mis_within", {63'd0, wc <= 110}, 64'd1);
    chk("mis_word", {54'd0, word_o[9:0]}, 64'h0AB);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (word_valid[0]) begin
        chk("mis_word_after", {54'd0, word_o[9:0]}, 64'h0AB);
        break;
      end
    end

    // manual mode: no auto slips, then five manual slips
    align_en = 1'b0;
    do_reset();
    fill_sym[0] = 10'h0AB;
    push_junk(0, 5);
    moved = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (locked[0] || bit_offset != 12'h000) moved = 1'b1;
    end
    chk("man_idle", {63'd0, moved}, 64'd0);
    for (int k = 0; k < 5; k++) begin
      slip_req = 3'b001;
      tick();
      slip_req = 3'b000;
      tick();
      tick();
    end
    for (int i = 0; i < 80; i++) begin
      tick();
      if (locked[0]) break;
    end
    chk("man_locked", {63'd0, locked[0]}, 64'd1);
    chk("man_offset", {52'd0, bit_offset}, 64'h005);

    // loss of lock on lane 1
    align_en = 1'b1;
    do_reset();
    fill_sym[0] = 10'h354; fill_sym[1] = 10'h2AB; fill_sym[2] = 10'h154;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (all_locked) break;
    end
    chk("loss_all_locked", {63'd0, all_locked}, 64'd1);
    fill_sym[1] = 10'h000;
    zc = 0;
    for (int i = 0; i < 12000; i++) begin
      tick();
      if (word_valid[1] && word_o[19:10] == 10'h000) begin
        zc++;
        if (zc == 4095) chk("loss_hold", {63'd0, locked[1]}, 64'd1);
        if (zc == 4096) begin
          chk("loss_drop", {63'd0, locked[1]}, 64'd0);
          break;
        end
      end
    end
    chk("loss_words", 64'(zc), 64'd4096);
    tick();
    chk("loss_all_drop", {63'd0, all_locked}, 64'd0);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bit_offset[7:4] != 4'd0) break;
    end
    chk("loss_research", {60'd0, bit_offset[7:4]}, 64'd1);
    chk("loss_others", {62'd0, locked[2], locked[0]}, 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
